// File: rtl/hmc6502_int_pkg.sv
// Shared types and constants for the 6502 interrupt sequencer.
package hmc6502_int_pkg;

  localparam int unsigned SRC_W         = 4;
  localparam int unsigned SRC_IRQ0_CODE = 3;

  typedef enum logic [2:0] {
    RST_VEC,
    IDLE,
    PEND,
    SEQ,
    VEC_LO,
    VEC_HI
  } state_e;

  typedef enum logic [SRC_W-1:0] {
    SRC_RESET = 4'd0,
    SRC_NMI   = 4'd1,
    SRC_BRK   = 4'd2,
    SRC_IRQ0  = 4'd3,
    SRC_IRQ1  = 4'd4,
    SRC_IRQ2  = 4'd5,
    SRC_IRQ3  = 4'd6,
    SRC_IRQ4  = 4'd7,
    SRC_IRQ5  = 4'd8,
    SRC_IRQ6  = 4'd9,
    SRC_IRQ7  = 4'd10
  } src_e;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_BRK   = 16'hFFFE;

endpackage

// File: rtl/irq_vector_ctrl_if.sv
// Core/peripheral <-> interrupt sequencer signal bundle.
interface irq_vector_ctrl_if
  import hmc6502_int_pkg::*;
#(
  parameter int unsigned N_IRQ  = 4,
  parameter int unsigned ADDR_W = 16
);

  logic [N_IRQ-1:0]  irq_req;
  logic [N_IRQ-1:0]  irq_en;
  logic              nmi_req;
  logic              brk_req;
  logic              i_flag;
  logic              boundary;
  logic              int_ack;
  logic              vec_rd;
  logic              int_pend;
  src_e              int_src;
  logic              b_flag;
  logic [ADDR_W-1:0] vec_addr;
  logic              int_done;

  modport master (
    output irq_req, irq_en, nmi_req, brk_req, i_flag, boundary, int_ack, vec_rd,
    input  int_pend, int_src, b_flag, vec_addr, int_done
  );

  modport slave (
    input  irq_req, irq_en, nmi_req, brk_req, i_flag, boundary, int_ack, vec_rd,
    output int_pend, int_src, b_flag, vec_addr, int_done
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: NMI > BRK > IRQ[0] > ... > IRQ[N_IRQ-1].
module irq_prio_enc
  import hmc6502_int_pkg::*;
#(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             nmi,
  input  logic             brk,
  input  logic [N_IRQ-1:0] irq,
  output logic             valid_c,
  output src_e             src_c
);

  always_comb begin
    valid_c = nmi | brk | (|irq);
    src_c   = SRC_RESET;
    // Walk from lowest to highest priority so the last hit wins.
    for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
      if (irq[k]) src_c = src_e'(SRC_W'(SRC_IRQ0_CODE + 32'(k)));
    end
    if (brk) src_c = SRC_BRK;
    if (nmi) src_c = SRC_NMI;
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// 6502 interrupt sequencer: source latching/arbitration, core handshake and
// vector address generation for RESET, NMI, BRK and N_IRQ IRQ channels.
module irq_vector_ctrl
  import hmc6502_int_pkg::*;
#(
  parameter int unsigned       N_IRQ        = 4,
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] IRQ_VEC_BASE = 16'hFFE0,
  parameter bit                LEGACY       = 1'b0,
  parameter bit                HIJACK       = 1'b1
) (
  input logic              ph1,
  input logic              reset,
  irq_vector_ctrl_if.slave bus
);

  state_e            state, state_d;
  src_e              src, src_d;
  logic              b_q, b_d;
  logic [ADDR_W-1:0] vaddr, vaddr_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              nmi_lat, nmi_lat_d;
  logic              nmi_prev;
  logic              brk_lat, brk_lat_d;
  logic              hij_brk, hij_brk_d;
  logic              clr_nmi, clr_brk;

  logic              nmi_edge, nmi_any, brk_any;
  logic [N_IRQ-1:0]  irq_elig;
  logic              enc_valid;
  src_e              enc_src;

  function automatic logic [ADDR_W-1:0] vec_of(input src_e s);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(32'(s) - SRC_IRQ0_CODE);
    if (s == SRC_NMI)        return ADDR_W'(VEC_NMI);
    else if (s == SRC_RESET) return ADDR_W'(VEC_RESET);
    else if (s == SRC_BRK)   return ADDR_W'(VEC_BRK);
    else if (LEGACY)         return ADDR_W'(VEC_BRK);
    else                     return IRQ_VEC_BASE + (off << 1);
  endfunction

  // Live events are OR'd with their latches so a source is visible the cycle it occurs.
  assign nmi_edge = bus.nmi_req & ~nmi_prev;
  assign nmi_any  = nmi_lat | nmi_edge;
  assign brk_any  = brk_lat | bus.brk_req;
  assign irq_elig = bus.irq_req & bus.irq_en & {N_IRQ{~bus.i_flag}};

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_enc (
    .nmi     (nmi_any),
    .brk     (brk_any),
    .irq     (irq_elig),
    .valid_c (enc_valid),
    .src_c   (enc_src)
  );

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state    <= RST_VEC;
      src      <= SRC_RESET;
      b_q      <= 1'b0;
      vaddr    <= ADDR_W'(VEC_RESET);
      pend_q   <= 1'b1;
      done_q   <= 1'b0;
      nmi_lat  <= 1'b0;
      nmi_prev <= 1'b0;
      brk_lat  <= 1'b0;
      hij_brk  <= 1'b0;
    end else begin
      state    <= state_d;
      src      <= src_d;
      b_q      <= b_d;
      vaddr    <= vaddr_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      nmi_lat  <= nmi_lat_d;
      nmi_prev <= bus.nmi_req;
      brk_lat  <= brk_lat_d;
      hij_brk  <= hij_brk_d;
    end
  end

  always_comb begin
    state_d   = state;
    src_d     = src;
    b_d       = b_q;
    vaddr_d   = vaddr;
    pend_d    = pend_q;
    done_d    = 1'b0;
    hij_brk_d = hij_brk;
    clr_nmi   = 1'b0;
    clr_brk   = 1'b0;

    unique case (state)
      RST_VEC: begin
        pend_d = 1'b1;
        if (bus.vec_rd) begin
          state_d = VEC_HI;
          pend_d  = 1'b0;
          vaddr_d = vaddr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (enc_valid && bus.boundary) begin
          state_d   = PEND;
          pend_d    = 1'b1;
          src_d     = enc_src;
          b_d       = (enc_src == SRC_BRK);
          vaddr_d   = vec_of(enc_src);
          hij_brk_d = 1'b0;
        end
      end
      PEND: begin
        if (bus.int_ack) begin
          state_d = SEQ;
          pend_d  = 1'b0;
        end else if (!enc_valid) begin
          // Only a level IRQ can vanish; NMI and BRK are latched.
          state_d = IDLE;
          pend_d  = 1'b0;
        end else begin
          src_d   = enc_src;
          b_d     = (enc_src == SRC_BRK);
          vaddr_d = vec_of(enc_src);
        end
      end
      SEQ: begin
        // NMOS-style hijack: NMI takes over the vector, pushed B is untouched.
        if (HIJACK && nmi_any && (src != SRC_NMI)) begin
          src_d     = SRC_NMI;
          vaddr_d   = ADDR_W'(VEC_NMI);
          hij_brk_d = (src == SRC_BRK);
        end
        if (bus.vec_rd) state_d = VEC_LO;
      end
      VEC_LO: begin
        if (bus.vec_rd) begin
          state_d = VEC_HI;
          vaddr_d = vaddr + ADDR_W'(1);
        end
      end
      VEC_HI: begin
        if (bus.vec_rd) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          clr_brk   = (src == SRC_BRK) | hij_brk;
          clr_nmi   = (src == SRC_NMI);
          hij_brk_d = 1'b0;
        end
      end
      default: state_d = RST_VEC;
    endcase

    // A new edge in the clearing cycle survives.
    nmi_lat_d = (nmi_lat & ~clr_nmi) | nmi_edge;
    brk_lat_d = (brk_lat & ~clr_brk) | bus.brk_req;
  end

  assign bus.int_pend = pend_q;
  assign bus.int_src  = src;
  assign bus.b_flag   = b_q;
  assign bus.vec_addr = vaddr;
  assign bus.int_done = done_q;

endmodule
